// File: rtl/ssd_bist_monitor_if.sv
// Signal bundle between the BIST chain taps, board switches and the display monitor.
// The chain side is the master; the monitor consumes it through the slave modport.
interface ssd_bist_monitor_if;
  logic       step_tgl;
  logic       scan_en;
  logic       scan_in;
  logic       scan_out;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] mode;
  logic [7:0] SSD_out;
  logic [3:0] SSD_bit;

  modport master (
    output step_tgl, scan_en, scan_in, scan_out, a, b, mode,
    input  SSD_out, SSD_bit
  );

  modport slave (
    input  step_tgl, scan_en, scan_in, scan_out, a, b, mode,
    output SSD_out, SSD_bit
  );
endinterface

// File: rtl/ssd_bist_monitor.sv
// Display-side BIST monitor: syncs chain taps into dclk_ssd, keeps scan history and
// step/shift counters, and scans one of four views onto a 4-digit active-low display.
module ssd_bist_monitor #(
  parameter int unsigned GUARD_CYCLES = 3
) (
  input  logic              dclk_ssd,
  input  logic              rst_n,
  ssd_bist_monitor_if.slave bus
);

  localparam logic [1:0] GUARD_INIT = 2'(GUARD_CYCLES);

  logic        step_s1, step_s2, step_s3;
  logic        scan_en_s1, scan_en_sync;
  logic        scan_in_s1, scan_in_sync;
  logic        scan_out_s1, scan_out_sync;
  logic [3:0]  a_s1, a_sync;
  logic [3:0]  b_s1, b_sync;
  logic [1:0]  mode_s1, mode_sync;

  logic [1:0]  guard;
  logic        step_evt;
  logic [15:0] hist;
  logic [15:0] step_cnt;
  logic [3:0]  shift_cnt;

  logic [3:0]  ssd_bit_q;
  logic [7:0]  ssd_out_q;
  logic [3:0]  next_bit;
  logic [1:0]  next_digit;
  logic [3:0]  nibble;
  logic        blank;

  function automatic logic [3:0] pick_nibble(input logic [15:0] word, input logic [1:0] digit);
    logic [3:0] res;
    case (digit)
      2'd0:    res = word[15:12];
      2'd1:    res = word[11:8];
      2'd2:    res = word[7:4];
      default: res = word[3:0];
    endcase
    return res;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] value);
    logic [7:0] res;
    case (value)
      4'h0:    res = 8'h03;
      4'h1:    res = 8'h9F;
      4'h2:    res = 8'h25;
      4'h3:    res = 8'h0D;
      4'h4:    res = 8'h99;
      4'h5:    res = 8'h49;
      4'h6:    res = 8'h41;
      4'h7:    res = 8'h1B;
      4'h8:    res = 8'h01;
      4'h9:    res = 8'h09;
      4'hA:    res = 8'h11;
      4'hB:    res = 8'hC1;
      4'hC:    res = 8'h63;
      4'hD:    res = 8'h85;
      4'hE:    res = 8'h61;
      default: res = 8'h71;
    endcase
    return res;
  endfunction

  // step_tgl gets a third stage so the edge detect compares two settled samples.
  always_ff @(posedge dclk_ssd) begin
    if (!rst_n) begin
      step_s1       <= 1'b0;
      step_s2       <= 1'b0;
      step_s3       <= 1'b0;
      scan_en_s1    <= 1'b0;
      scan_en_sync  <= 1'b0;
      scan_in_s1    <= 1'b0;
      scan_in_sync  <= 1'b0;
      scan_out_s1   <= 1'b0;
      scan_out_sync <= 1'b0;
      a_s1          <= 4'h0;
      a_sync        <= 4'h0;
      b_s1          <= 4'h0;
      b_sync        <= 4'h0;
      mode_s1       <= 2'd0;
      mode_sync     <= 2'd0;
    end else begin
      step_s1       <= bus.step_tgl;
      step_s2       <= step_s1;
      step_s3       <= step_s2;
      scan_en_s1    <= bus.scan_en;
      scan_en_sync  <= scan_en_s1;
      scan_in_s1    <= bus.scan_in;
      scan_in_sync  <= scan_in_s1;
      scan_out_s1   <= bus.scan_out;
      scan_out_sync <= scan_out_s1;
      a_s1          <= bus.a;
      a_sync        <= a_s1;
      b_s1          <= bus.b;
      b_sync        <= b_s1;
      mode_s1       <= bus.mode;
      mode_sync     <= mode_s1;
    end
  end

  // The guard hides the toggle edge a non-zero step_tgl level fakes at reset release.
  assign step_evt = (step_s2 ^ step_s3) && (guard == 2'd0);

  always_ff @(posedge dclk_ssd) begin
    if (!rst_n) begin
      guard     <= GUARD_INIT;
      hist      <= 16'h0000;
      step_cnt  <= 16'h0000;
      shift_cnt <= 4'h0;
    end else begin
      if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end
      if (step_evt) begin
        hist     <= {hist[14:0], scan_out_sync};
        step_cnt <= step_cnt + 16'h0001;
        if (!scan_en_sync) begin
          shift_cnt <= 4'h0;
        end else if (shift_cnt < 4'd8) begin
          shift_cnt <= shift_cnt + 4'h1;
        end
      end
    end
  end

  assign next_bit = {ssd_bit_q[0], ssd_bit_q[3:1]};

  always_comb begin
    case (ssd_bit_q)
      4'b0111: next_digit = 2'd1;
      4'b1011: next_digit = 2'd2;
      4'b1101: next_digit = 2'd3;
      default: next_digit = 2'd0;
    endcase
  end

  // View mux for the digit about to be enabled, using pre-edge counters.
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    case (mode_sync)
      2'd0: begin
        case (next_digit)
          2'd0:    nibble = {3'b000, scan_in_sync};
          2'd1:    nibble = a_sync;
          2'd2:    nibble = b_sync;
          default: nibble = {3'b000, scan_out_sync};
        endcase
      end
      2'd1:    nibble = pick_nibble(hist, next_digit);
      2'd2:    nibble = pick_nibble(step_cnt, next_digit);
      default: begin
        case (next_digit)
          2'd0: begin
            nibble = 4'hF;
            blank  = (shift_cnt != 4'd8);
          end
          2'd3:    nibble = shift_cnt;
          default: blank  = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge dclk_ssd) begin
    if (!rst_n) begin
      ssd_bit_q <= 4'b0111;
      ssd_out_q <= 8'hFF;
    end else begin
      ssd_bit_q <= next_bit;
      ssd_out_q <= blank ? 8'hFF : seg_code(nibble);
    end
  end

  assign bus.SSD_bit = ssd_bit_q;
  assign bus.SSD_out = ssd_out_q;

endmodule

// File: tb/tb_ssd_bist_monitor.sv
// Scoreboard bench for ssd_bist_monitor: a cycle model of sampled inputs predicts every
// displayed digit; a separate monitor pops predictions and compares on the falling edge.
module tb_ssd_bist_monitor;

  localparam int GUARD = 3;

  typedef struct {
    logic       tgl;
    logic       en;
    logic       si;
    logic       so;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] mode;
  } samp_t;

  typedef struct {
    logic [3:0] bits;
    logic [7:0] seg;
  } exp_t;

  logic dclk_ssd = 1'b0;
  logic rst_n    = 1'b0;

  ssd_bist_monitor_if bus ();

  ssd_bist_monitor #(.GUARD_CYCLES(GUARD)) dut (
    .dclk_ssd (dclk_ssd),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 dclk_ssd = ~dclk_ssd;

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1B,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  samp_t       hq[$];
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  bit          check_en = 1'b0;
  bit          model_live = 1'b0;
  logic [15:0] m_hist;
  logic [15:0] m_step;
  int          m_shift;
  int          m_digit;
  int          m_since;

  // Reference: synced value seen before edge j is the input sampled two edges earlier.
  task automatic model_edge();
    samp_t cur, syn, old, zero_s;
    exp_t  e;
    int    d;
    int    val;
    bit    blank;
    zero_s = '{tgl: 1'b0, en: 1'b0, si: 1'b0, so: 1'b0, a: 4'h0, b: 4'h0, mode: 2'd0};
    if (rst_n !== 1'b1) begin
      hq.delete();
      repeat (4) hq.push_back(zero_s);
      m_hist = 16'h0; m_step = 16'h0; m_shift = 0; m_digit = 0; m_since = 0;
      model_live = 1'b1;
      if (check_en) sb.push_back('{bits: 4'b0111, seg: 8'hFF});
    end else if (model_live) begin
      cur = '{tgl: bus.step_tgl, en: bus.scan_en, si: bus.scan_in, so: bus.scan_out,
              a: bus.a, b: bus.b, mode: bus.mode};
      hq.push_front(cur);
      void'(hq.pop_back());
      syn = hq[2];
      old = hq[3];
      m_since++;
      d     = (m_digit + 1) % 4;
      blank = 1'b0;
      val   = 0;
      case (syn.mode)
        2'd0: begin
          if (d == 0) val = int'(syn.si);
          else if (d == 1) val = int'(syn.a);
          else if (d == 2) val = int'(syn.b);
          else val = int'(syn.so);
        end
        2'd1: val = (int'(m_hist) >> (12 - 4 * d)) % 16;
        2'd2: val = (int'(m_step) >> (12 - 4 * d)) % 16;
        default: begin
          if (d == 0) begin val = 15; blank = (m_shift != 8); end
          else if (d == 3) val = m_shift;
          else blank = 1'b1;
        end
      endcase
      e.bits = 4'b1111 ^ (4'b1000 >> d);
      e.seg  = blank ? 8'hFF : seg_tab[val];
      if (check_en) sb.push_back(e);
      m_digit = d;
      if ((syn.tgl != old.tgl) && (m_since > GUARD)) begin
        m_hist  = {m_hist[14:0], syn.so};
        m_step  = m_step + 16'h1;
        m_shift = syn.en ? ((m_shift < 8) ? m_shift + 1 : 8) : 0;
      end
    end
  endtask

  initial forever begin
    @(posedge dclk_ssd);
    model_edge();
  end

  task automatic check_output(input exp_t e);
    tests++;
    if (bus.SSD_bit !== e.bits || bus.SSD_out !== e.seg) begin
      fails++;
      $display("[TB] FAIL display t=%0t: got SSD_bit=%b SSD_out=%h, want SSD_bit=%b SSD_out=%h",
               $time, bus.SSD_bit, bus.SSD_out, e.bits, e.seg);
    end
  endtask

  initial forever begin
    @(negedge dclk_ssd);
    if (sb.size() > 0) check_output(sb.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) @(negedge dclk_ssd);
  endtask

  task automatic apply_stimulus(input logic so, input logic en, input int gap);
    @(negedge dclk_ssd);
    bus.scan_out = so;
    bus.scan_en  = en;
    bus.step_tgl = ~bus.step_tgl;
    tick(gap - 1);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge dclk_ssd);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  logic [7:0] pat;

  initial begin
    bus.step_tgl = 1'b1;
    bus.scan_en  = 1'b0;
    bus.scan_in  = 1'b0;
    bus.scan_out = 1'b0;
    bus.a        = 4'h0;
    bus.b        = 4'h0;
    bus.mode     = 2'd1;
    rst_n        = 1'b0;
    check_en     = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);

    bus.mode = 2'd0; bus.a = 4'hA; bus.b = 4'h3; bus.scan_in = 1'b1; bus.scan_out = 1'b0;
    tick(16);

    bus.mode = 2'd1;
    apply_stimulus(1'b1, 1'b1, 10);
    apply_stimulus(1'b0, 1'b1, 10);
    apply_stimulus(1'b1, 1'b1, 10);
    apply_stimulus(1'b1, 1'b1, 10);
    tick(8);

    bus.mode = 2'd3;
    for (int i = 0; i < 10; i++) apply_stimulus(1'($urandom_range(0, 1)), 1'b1, 4);
    tick(8);
    apply_stimulus(1'b0, 1'b0, 12);

    for (int i = 0; i < 150; i++) begin
      bus.mode    = 2'($urandom_range(0, 3));
      bus.a       = 4'($urandom_range(0, 15));
      bus.b       = 4'($urandom_range(0, 15));
      bus.scan_in = 1'($urandom_range(0, 1));
      apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                     $urandom_range(3, 9));
    end
    tick(6);

    pulse_reset(1);
    tick(5);
    bus.mode = 2'd1;
    pat = 8'hB5;
    for (int i = 7; i >= 0; i--) apply_stimulus(pat[i], 1'b1, 5);
    tick(8);
    @(negedge dclk_ssd);
    rst_n = 1'b0;
    @(negedge dclk_ssd);
    rst_n        = 1'b1;
    bus.step_tgl = ~bus.step_tgl;
    tick(20);

    // Back-to-back toggles still register one step per edge, which keeps the wrap run short.
    bus.mode = 2'd2;
    pulse_reset(1);
    tick(5);
    check_en = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      @(negedge dclk_ssd);
      bus.scan_out = 1'($urandom_range(0, 1));
      bus.step_tgl = ~bus.step_tgl;
    end
    tick(6);
    check_en = 1'b1;
    tick(16);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
